// File: rtl/joystick_poller.sv
// Autonomous 1..4 channel PmodJSTK poller: mode-0 SPI master, poll timer and per-channel registered outputs.
// Optional centre dead zone on committed x/y is enabled by defining JOYSTICK_DEADZONE_EN.
module joystick_poller #(
   parameter int NCH         = 2,
   parameter int CLK_DIV     = 25,
   parameter int CS_SETUP    = 750,
   parameter int BYTE_GAP    = 500,
   parameter int POLL_PERIOD = 500000,
   parameter int DEADZONE    = 16
) (
   input  logic                clk50M,
   input  logic                rst,
   input  logic                enable,
   input  logic [2*NCH-1:0]    led,
   output logic [10*NCH-1:0]   x,
   output logic [10*NCH-1:0]   y,
   output logic [3*NCH-1:0]    btn,
   output logic [NCH-1:0]      valid,
   output logic                busy,
   output logic                sck,
   output logic                mosi,
   input  logic                miso,
   output logic [NCH-1:0]      cs
);

`ifdef JOYSTICK_DEADZONE_EN
   localparam bit DZ_ON = 1'b1;
`else
   localparam bit DZ_ON = 1'b0;
`endif

   localparam int TICK_W = $clog2(POLL_PERIOD);
   localparam int HALF_W = $clog2(CLK_DIV);
   localparam int CNT_MAX = (CS_SETUP > BYTE_GAP) ? CS_SETUP : BYTE_GAP;
   localparam int CNT_W = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      GAP,
      FINISH,
      INTERCH
   } state_t;

   state_t              r_state;
   logic [TICK_W-1:0]   r_tickCnt;
   logic [CNT_W-1:0]    r_cnt;
   logic [HALF_W-1:0]   r_halfCnt;
   logic [3:0]          r_halfIdx;
   logic [2:0]          r_byteIdx;
   logic [1:0]          r_ch;
   logic [6:0]          r_tx;
   logic [7:0]          r_rx;
   logic [7:0]          r_b0;
   logic [1:0]          r_b1;
   logic [7:0]          r_b2;
   logic [1:0]          r_b3;
   logic [2:0]          r_b4;

   logic                w_tick;
   logic                w_start;
   logic                w_lastCh;
   logic                w_enterSetup;
   logic [1:0]          w_enterCh;
   logic [1:0]          w_ledSel;
   logic [NCH-1:0]      w_csNext;
   logic [7:0]          w_byte0;
   logic [9:0]          w_xNew;
   logic [9:0]          w_yNew;

   // Values within DEADZONE of centre snap to 512; the signed 11-bit distance covers the full 0..1023 range.
   function automatic logic [9:0] applyDeadzone(input logic [9:0] v);
      logic signed [10:0] diff;
      logic signed [10:0] mag;
      diff = $signed({1'b0, v}) - 11'sd512;
      mag  = (diff < 0) ? -diff : diff;
      if (DZ_ON && (mag <= $signed(11'(DEADZONE))))
         return 10'd512;
      else
         return v;
   endfunction

   assign w_tick   = (r_tickCnt == TICK_W'(POLL_PERIOD - 1));
   assign w_start  = w_tick & enable;
   assign w_lastCh = (r_ch == 2'(NCH - 1));

   assign w_enterSetup = ((r_state == IDLE) && w_start) ||
                         ((r_state == FINISH) && w_lastCh && w_start) ||
                         ((r_state == FINISH) && !w_lastCh && (BYTE_GAP == 1)) ||
                         ((r_state == INTERCH) && (r_cnt == '0));

   assign w_enterCh = ((r_state == INTERCH) || ((r_state == FINISH) && !w_lastCh)) ?
                      (r_ch + 2'd1) : 2'd0;

   always_comb begin
      w_ledSel = 2'b00;
      w_csNext = '1;
      for (int i = 0; i < NCH; i++) begin
         if (2'(i) == w_enterCh) begin
            w_ledSel    = led[2*i +: 2];
            w_csNext[i] = 1'b0;
         end
      end
   end

   assign w_byte0 = {6'b100000, w_ledSel};
   assign w_xNew  = applyDeadzone({r_b1, r_b0});
   assign w_yNew  = applyDeadzone({r_b3, r_b2});

   always_ff @(posedge clk50M) begin
      if (rst || w_tick)
         r_tickCnt <= '0;
      else
         r_tickCnt <= r_tickCnt + 1'b1;
   end

   // The trailing sck-low cycle after byte 4 reuses GAP with a length of one, so FINISH lands one cycle after the last fall.
   always_ff @(posedge clk50M) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_halfCnt <= '0;
         r_halfIdx <= '0;
         r_byteIdx <= '0;
         r_ch      <= '0;
         r_tx      <= '0;
         r_rx      <= '0;
         r_b0      <= '0;
         r_b1      <= '0;
         r_b2      <= '0;
         r_b3      <= '0;
         r_b4      <= '0;
         cs        <= '1;
         sck       <= 1'b0;
         mosi      <= 1'b0;
         busy      <= 1'b0;
         valid     <= '0;
         btn       <= '0;
         for (int i = 0; i < NCH; i++) begin
            x[10*i +: 10] <= 10'd512;
            y[10*i +: 10] <= 10'd512;
         end
      end else begin
         valid <= '0;
         case (r_state)
            IDLE: begin
               r_state <= IDLE;
            end
            SETUP: begin
               if (r_cnt == '0) begin
                  r_state   <= SHIFT;
                  r_halfCnt <= '0;
                  r_halfIdx <= '0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            SHIFT: begin
               if (r_halfCnt == HALF_W'(CLK_DIV - 1)) begin
                  r_halfCnt <= '0;
                  r_halfIdx <= r_halfIdx + 1'b1;
                  sck       <= ~sck;
                  if (!sck) begin
                     r_rx <= {r_rx[6:0], miso};
                  end else begin
                     mosi <= r_tx[6];
                     r_tx <= {r_tx[5:0], 1'b0};
                  end
                  if (r_halfIdx == 4'd15) begin
                     case (r_byteIdx)
                        3'd0:    r_b0 <= r_rx;
                        3'd1:    r_b1 <= r_rx[1:0];
                        3'd2:    r_b2 <= r_rx;
                        3'd3:    r_b3 <= r_rx[1:0];
                        default: r_b4 <= r_rx[2:0];
                     endcase
                     r_state   <= GAP;
                     r_cnt     <= (r_byteIdx == 3'd4) ? '0 : CNT_W'(BYTE_GAP - 1);
                     r_byteIdx <= r_byteIdx + 1'b1;
                  end
               end else begin
                  r_halfCnt <= r_halfCnt + 1'b1;
               end
            end
            GAP: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else if (r_byteIdx == 3'd5) begin
                  r_state <= FINISH;
                  cs      <= '1;
                  if (w_lastCh)
                     busy <= 1'b0;
                  for (int i = 0; i < NCH; i++) begin
                     if (2'(i) == r_ch) begin
                        valid[i]      <= 1'b1;
                        x[10*i +: 10] <= w_xNew;
                        y[10*i +: 10] <= w_yNew;
                        btn[3*i +: 3] <= r_b4;
                     end
                  end
               end else begin
                  r_state   <= SHIFT;
                  r_halfCnt <= '0;
                  r_halfIdx <= '0;
               end
            end
            FINISH: begin
               if (w_lastCh) begin
                  r_state <= IDLE;
               end else if (BYTE_GAP > 1) begin
                  r_state <= INTERCH;
                  r_cnt   <= CNT_W'(BYTE_GAP - 2);
               end
            end
            INTERCH: begin
               r_cnt <= r_cnt - 1'b1;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase

         // Every path into SETUP (new scan or next channel) shares this entry: led is sampled here.
         if (w_enterSetup) begin
            r_state   <= SETUP;
            r_ch      <= w_enterCh;
            r_cnt     <= CNT_W'(CS_SETUP - 1);
            r_byteIdx <= '0;
            r_tx      <= w_byte0[6:0];
            mosi      <= w_byte0[7];
            sck       <= 1'b0;
            cs        <= w_csNext;
            busy      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_joystick_poller.sv
// Directed bench for joystick_poller: reset, two-channel scan timing, mid-transaction reset, enable gating, dead zone.
module tb_joystick_poller;

   localparam int NCH         = 2;
   localparam int CLK_DIV     = 2;
   localparam int CS_SETUP    = 4;
   localparam int BYTE_GAP    = 3;
   localparam int POLL_PERIOD = 2000;

`ifdef JOYSTICK_DEADZONE_EN
   localparam logic [9:0] EXP_DZ_X0 = 10'd512;
   localparam logic [9:0] EXP_DZ_X1 = 10'd512;
`else
   localparam logic [9:0] EXP_DZ_X0 = 10'd520;
   localparam logic [9:0] EXP_DZ_X1 = 10'd528;
`endif

   logic                clk50M = 1'b0;
   logic                rst    = 1'b1;
   logic                enable = 1'b1;
   logic [2*NCH-1:0]    led    = 4'b0110;
   logic [10*NCH-1:0]   x;
   logic [10*NCH-1:0]   y;
   logic [3*NCH-1:0]    btn;
   logic [NCH-1:0]      valid;
   logic                busy;
   logic                sck;
   logic                mosi;
   logic                miso   = 1'b0;
   logic [NCH-1:0]      cs;

   int checks   = 0;
   int failures = 0;

   logic [39:0] respCh  [2];
   logic [39:0] mosiCap [2];
   logic        prevSck = 1'b0;
   logic [1:0]  prevCs  = 2'b11;
   int          bitPtr  = 0;
   int          selCh   = 0;
   logic [19:0] expMid;

   joystick_poller #(
      .NCH(NCH), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .BYTE_GAP(BYTE_GAP),
      .POLL_PERIOD(POLL_PERIOD), .DEADZONE(16)
   ) dut (
      .clk50M(clk50M), .rst(rst), .enable(enable), .led(led),
      .x(x), .y(y), .btn(btn), .valid(valid), .busy(busy),
      .sck(sck), .mosi(mosi), .miso(miso), .cs(cs)
   );

   always #5 clk50M = ~clk50M;

   // Joystick slave model: presents MSB-first response bits, advancing on each sck fall, and records mosi on each rise.
   always @(posedge clk50M) begin
      #1;
      if (prevCs[0] && !cs[0]) begin
         selCh = 0; bitPtr = 0; miso = respCh[0][39]; mosiCap[0] = '0;
      end else if (prevCs[1] && !cs[1]) begin
         selCh = 1; bitPtr = 0; miso = respCh[1][39]; mosiCap[1] = '0;
      end else if (prevSck && !sck) begin
         bitPtr++;
         miso = (bitPtr < 40) ? respCh[selCh][39-bitPtr] : 1'b0;
      end
      if (!prevSck && sck)
         mosiCap[selCh] = {mosiCap[selCh][38:0], mosi};
      prevSck = sck;
      prevCs  = cs;
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk50M);
      checks++; if (cs !== 2'b11) begin failures++; $display("[TB] FAIL reset_cs: got %b want %b", cs, 2'b11); end
      checks++; if (sck !== 1'b0) begin failures++; $display("[TB] FAIL reset_sck: got %b want 0", sck); end
      checks++; if (mosi !== 1'b0) begin failures++; $display("[TB] FAIL reset_mosi: got %b want 0", mosi); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      checks++; if (valid !== 2'b00) begin failures++; $display("[TB] FAIL reset_valid: got %b want 00", valid); end
      checks++; if (x !== expMid) begin failures++; $display("[TB] FAIL reset_x: got %h want %h", x, expMid); end
      checks++; if (y !== expMid) begin failures++; $display("[TB] FAIL reset_y: got %h want %h", y, expMid); end
      checks++; if (btn !== 6'b0) begin failures++; $display("[TB] FAIL reset_btn: got %b want 0", btn); end
      rst = 1'b0;
   endtask

   task automatic test_first_tick();
      repeat (1999) @(negedge clk50M);
      checks++; if (cs !== 2'b11) begin failures++; $display("[TB] FAIL pre_tick_cs: got %b want 11", cs); end
      checks++; if (valid !== 2'b00) begin failures++; $display("[TB] FAIL pre_tick_valid: got %b want 00", valid); end
      @(negedge clk50M);
      checks++; if (cs !== 2'b10) begin failures++; $display("[TB] FAIL tick_cs0_fall: got %b want 10", cs); end
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL tick_busy: got %b want 1", busy); end
   endtask

   task automatic test_channel0();
      for (int t = 1; t <= 177; t++) begin
         @(negedge clk50M);
         if (t == 4) begin
            checks++; if (sck !== 1'b0 || mosi !== 1'b1) begin failures++; $display("[TB] FAIL ch0_shift_entry: got sck=%b mosi=%b want sck=0 mosi=1", sck, mosi); end
         end
         if (t == 6) begin
            checks++; if (sck !== 1'b1) begin failures++; $display("[TB] FAIL ch0_first_rise: got %b want 1", sck); end
         end
         if (t == 176) begin
            checks++; if (valid !== 2'b00 || cs !== 2'b10) begin failures++; $display("[TB] FAIL ch0_pre_finish: got valid=%b cs=%b want 00/10", valid, cs); end
         end
      end
      checks++; if (valid !== 2'b01) begin failures++; $display("[TB] FAIL ch0_valid: got %b want 01", valid); end
      checks++; if (cs !== 2'b11) begin failures++; $display("[TB] FAIL ch0_cs_rise: got %b want 11", cs); end
      checks++; if (x[9:0] !== 10'h234) begin failures++; $display("[TB] FAIL ch0_x: got %h want 234", x[9:0]); end
      checks++; if (y[9:0] !== 10'h1CD) begin failures++; $display("[TB] FAIL ch0_y: got %h want 1cd", y[9:0]); end
      checks++; if (btn[2:0] !== 3'b101) begin failures++; $display("[TB] FAIL ch0_btn: got %b want 101", btn[2:0]); end
      checks++; if (x[19:10] !== 10'd512) begin failures++; $display("[TB] FAIL ch1_x_untouched: got %h want 200", x[19:10]); end
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL ch0_busy: got %b want 1", busy); end
      checks++; if (mosiCap[0] !== {8'h82, 32'h0}) begin failures++; $display("[TB] FAIL ch0_mosi: got %h want 8200000000", mosiCap[0]); end
   endtask

   task automatic test_channel1();
      repeat (2) @(negedge clk50M);
      checks++; if (cs !== 2'b11) begin failures++; $display("[TB] FAIL interch_cs: got %b want 11", cs); end
      @(negedge clk50M);
      checks++; if (cs !== 2'b01) begin failures++; $display("[TB] FAIL ch1_cs_fall: got %b want 01", cs); end
      repeat (176) @(negedge clk50M);
      checks++; if (valid !== 2'b00) begin failures++; $display("[TB] FAIL ch1_pre_finish: got %b want 00", valid); end
      @(negedge clk50M);
      checks++; if (valid !== 2'b10) begin failures++; $display("[TB] FAIL ch1_valid: got %b want 10", valid); end
      checks++; if (cs !== 2'b11 || busy !== 1'b0) begin failures++; $display("[TB] FAIL ch1_end: got cs=%b busy=%b want 11/0", cs, busy); end
      checks++; if (x[19:10] !== 10'h3FF || y[19:10] !== 10'h000) begin failures++; $display("[TB] FAIL ch1_xy: got %h/%h want 3ff/000", x[19:10], y[19:10]); end
      checks++; if (btn[5:3] !== 3'b010) begin failures++; $display("[TB] FAIL ch1_btn: got %b want 010", btn[5:3]); end
      checks++; if (x[9:0] !== 10'h234) begin failures++; $display("[TB] FAIL ch0_x_held: got %h want 234", x[9:0]); end
      checks++; if (mosiCap[1] !== {8'h81, 32'h0}) begin failures++; $display("[TB] FAIL ch1_mosi: got %h want 8100000000", mosiCap[1]); end
      @(negedge clk50M);
      checks++; if (valid !== 2'b00) begin failures++; $display("[TB] FAIL ch1_valid_pulse: got %b want 00", valid); end
   endtask

   task automatic test_reset_mid();
      respCh[0] = 40'hAA_AB_AA_AB_07;
      repeat (1642) @(negedge clk50M);
      checks++; if (cs !== 2'b10) begin failures++; $display("[TB] FAIL scan2_cs0_fall: got %b want 10", cs); end
      repeat (80) @(negedge clk50M);
      rst = 1'b1;
      @(negedge clk50M);
      checks++; if (cs !== 2'b11 || sck !== 1'b0 || mosi !== 1'b0) begin failures++; $display("[TB] FAIL midrst_spi: got cs=%b sck=%b mosi=%b want 11/0/0", cs, sck, mosi); end
      checks++; if (busy !== 1'b0 || valid !== 2'b00) begin failures++; $display("[TB] FAIL midrst_busy_valid: got %b/%b want 0/00", busy, valid); end
      checks++; if (x !== expMid || y !== expMid || btn !== 6'b0) begin failures++; $display("[TB] FAIL midrst_outputs: got x=%h y=%h btn=%b", x, y, btn); end
      rst = 1'b0;
   endtask

   task automatic test_enable();
      int badCs    = 0;
      int badValid = 0;
      enable = 1'b0;
      for (int k = 1; k <= 2100; k++) begin
         @(negedge clk50M);
         if (cs !== 2'b11) badCs++;
         if (valid !== 2'b00) badValid++;
      end
      checks++; if (badCs !== 0) begin failures++; $display("[TB] FAIL disabled_cs_activity: got %0d cycles want 0", badCs); end
      checks++; if (badValid !== 0) begin failures++; $display("[TB] FAIL disabled_valid: got %0d cycles want 0", badValid); end
      enable    = 1'b1;
      respCh[0] = {8'h08, 8'h02, 8'hEA, 8'h01, 8'h00};
      respCh[1] = {8'h10, 8'h02, 8'hEF, 8'h01, 8'h07};
      repeat (1899) @(negedge clk50M);
      checks++; if (cs !== 2'b11) begin failures++; $display("[TB] FAIL reenable_pre_tick: got %b want 11", cs); end
      @(negedge clk50M);
      checks++; if (cs !== 2'b10) begin failures++; $display("[TB] FAIL reenable_scan: got %b want 10", cs); end
   endtask

   task automatic test_deadzone();
      repeat (177) @(negedge clk50M);
      checks++; if (valid !== 2'b01) begin failures++; $display("[TB] FAIL dz_valid0: got %b want 01", valid); end
      checks++; if (x[9:0] !== EXP_DZ_X0) begin failures++; $display("[TB] FAIL dz_x0: got %0d want %0d", x[9:0], EXP_DZ_X0); end
      checks++; if (y[9:0] !== 10'd490) begin failures++; $display("[TB] FAIL dz_y0: got %0d want 490", y[9:0]); end
      repeat (180) @(negedge clk50M);
      checks++; if (valid !== 2'b10) begin failures++; $display("[TB] FAIL dz_valid1: got %b want 10", valid); end
      checks++; if (x[19:10] !== EXP_DZ_X1) begin failures++; $display("[TB] FAIL dz_x1_edge: got %0d want %0d", x[19:10], EXP_DZ_X1); end
      checks++; if (y[19:10] !== 10'd495) begin failures++; $display("[TB] FAIL dz_y1_outside: got %0d want 495", y[19:10]); end
      checks++; if (btn[5:3] !== 3'b111) begin failures++; $display("[TB] FAIL dz_btn1: got %b want 111", btn[5:3]); end
   endtask

   initial begin
      expMid     = {10'd512, 10'd512};
      respCh[0]  = {8'h34, 8'h02, 8'hCD, 8'h01, 8'h05};
      respCh[1]  = {8'hFF, 8'h03, 8'h00, 8'h00, 8'h02};
      mosiCap[0] = '0;
      mosiCap[1] = '0;
      test_reset();
      test_first_tick();
      test_channel0();
      test_channel1();
      test_reset_mid();
      test_enable();
      test_deadzone();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
